inst_mem_pipe: RTL and testbench



---
 rtl/inst_mem_pipe_if.sv | 29 ++
 rtl/inst_mem_pipe.sv | 129 ++++++++++++
 tb/tb_inst_mem_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_pipe_if.sv
// Fetch request/response bundle between the CPU fetch stage (master) and
// the pipelined instruction memory (slave).
interface inst_mem_pipe_if #(
    parameter int ADDR_W  = 64,
    parameter int INST_W  = 32,
    parameter int FETCH_N = 1,
    parameter int LATENCY = 6
);
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic                        i_valid;
    logic [ADDR_W-1:0]           i_addr;
    logic                        i_flush;
    logic                        o_valid;
    logic [INST_W*FETCH_N-1:0]   o_inst;
    logic [FETCH_N-1:0]          o_lane_ok;
    logic                        o_err;
    logic [CNT_W-1:0]            o_inflight;

    modport master (
        output i_valid, i_addr, i_flush,
        input  o_valid, o_inst, o_lane_ok, o_err, o_inflight
    );

    modport slave (
        input  i_valid, i_addr, i_flush,
        output o_valid, o_inst, o_lane_ok, o_err, o_inflight
    );
endinterface

// File: rtl/inst_mem_pipe.sv
// Fully pipelined instruction memory: one fetch per cycle, FETCH_N words
// returned LATENCY cycles later, with flush-on-redirect and range/alignment errors.
module inst_mem_pipe #(
    parameter int ADDR_W   = 64,
    parameter int INST_W   = 32,
    parameter int MAX_INST = 256,
    parameter int LATENCY  = 6,
    parameter int FETCH_N  = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    inst_mem_pipe_if.slave bus
);
    localparam int BYTES  = INST_W / 8;
    localparam int OFF    = $clog2(BYTES);
    localparam int MEM_AW = (MAX_INST > 1) ? $clog2(MAX_INST) : 1;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(MAX_INST);

    // Not reset: contents are loaded before reset is released.
    logic [INST_W-1:0] mem [0:MAX_INST-1];

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [ADDR_W-1:0]  idx_q [LATENCY];
    logic [LATENCY-1:0] mis_q;
    logic [ADDR_W-1:0]  req_idx;
    logic               req_mis;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               fin_vld;
    logic               fin_mis;
    logic [ADDR_W-1:0]  fin_idx;
    logic [FETCH_N-1:0] lane_in;

    logic                      valid_q;
    logic                      err_q;
    logic                      err_d;
    logic [FETCH_N-1:0]        ok_q;
    logic [FETCH_N-1:0]        ok_d;
    logic [INST_W*FETCH_N-1:0] inst_q;
    logic [INST_W*FETCH_N-1:0] inst_d;

    assign req_idx = bus.i_addr >> OFF;

    generate
        if (OFF == 0) begin : g_byte_inst
            assign req_mis = 1'b0;
        end else begin : g_align
            assign req_mis = |bus.i_addr[OFF-1:0];
        end
    endgenerate

    // Flush kills everything already in flight but still admits the redirect target.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = bus.i_valid;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1] & ~bus.i_flush;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge i_clk) begin
        idx_q[0] <= req_idx;
        mis_q[0] <= req_mis;
        for (int i = 1; i < LATENCY; i++) begin
            idx_q[i] <= idx_q[i-1];
            mis_q[i] <= mis_q[i-1];
        end
    end

    assign fin_vld = vld_q[LATENCY-1];
    assign fin_mis = mis_q[LATENCY-1];
    assign fin_idx = idx_q[LATENCY-1];

    always_comb begin
        if (bus.i_flush) begin
            cnt_d = CNT_W'(bus.i_valid);
        end else begin
            cnt_d = cnt_q + CNT_W'(bus.i_valid) - CNT_W'(fin_vld);
        end
    end

    // Lane index kept at full address width so indices near the top never wrap into range.
    genvar gi;
    generate
        for (gi = 0; gi < FETCH_N; gi++) begin : g_lane
            logic [ADDR_W-1:0] lane_idx;
            assign lane_idx    = fin_idx + ADDR_W'(gi);
            assign lane_in[gi] = lane_idx < MAX_IDX;
            assign inst_d[gi*INST_W +: INST_W] =
                (fin_vld && !fin_mis && lane_in[gi]) ? mem[lane_idx[MEM_AW-1:0]] : '0;
        end
    endgenerate

    assign ok_d  = {FETCH_N{fin_vld & ~fin_mis}} & lane_in;
    assign err_d = fin_vld & (fin_mis | ~lane_in[0]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ok_q    <= '0;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= fin_vld;
            err_q   <= err_d;
            ok_q    <= ok_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;
    assign bus.o_lane_ok  = ok_q;
    assign bus.o_inst     = inst_q;
    assign bus.o_inflight = cnt_q;
endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: four parameterisations checked every cycle against a
// due-time schedule model, plus directed sequences and a boundary vector table.
module tb_inst_mem_pipe;
    localparam int NI   = 4;
    localparam int MAXI = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         drv_valid [NI];
    logic [63:0]  drv_addr  [NI];
    logic         drv_flush [NI];
    logic         obs_valid [NI];
    logic [127:0] obs_inst  [NI];
    logic [3:0]   obs_ok    [NI];
    logic         obs_err   [NI];
    logic [3:0]   obs_infl  [NI];

    inst_mem_pipe_if #(.ADDR_W(64), .INST_W(32), .FETCH_N(1), .LATENCY(6)) if0 ();
    inst_mem_pipe_if #(.ADDR_W(64), .INST_W(32), .FETCH_N(2), .LATENCY(6)) if1 ();
    inst_mem_pipe_if #(.ADDR_W(64), .INST_W(32), .FETCH_N(4), .LATENCY(1)) if2 ();
    inst_mem_pipe_if #(.ADDR_W(64), .INST_W(32), .FETCH_N(4), .LATENCY(8)) if3 ();

    inst_mem_pipe #(.ADDR_W(64), .INST_W(32), .MAX_INST(MAXI), .LATENCY(6), .FETCH_N(1))
        u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    inst_mem_pipe #(.ADDR_W(64), .INST_W(32), .MAX_INST(MAXI), .LATENCY(6), .FETCH_N(2))
        u1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    inst_mem_pipe #(.ADDR_W(64), .INST_W(32), .MAX_INST(MAXI), .LATENCY(1), .FETCH_N(4))
        u2 (.i_clk(clk), .i_rst(rst), .bus(if2));
    inst_mem_pipe #(.ADDR_W(64), .INST_W(32), .MAX_INST(MAXI), .LATENCY(8), .FETCH_N(4))
        u3 (.i_clk(clk), .i_rst(rst), .bus(if3));

    assign if0.i_valid = drv_valid[0];
    assign if0.i_addr  = drv_addr[0];
    assign if0.i_flush = drv_flush[0];
    assign if1.i_valid = drv_valid[1];
    assign if1.i_addr  = drv_addr[1];
    assign if1.i_flush = drv_flush[1];
    assign if2.i_valid = drv_valid[2];
    assign if2.i_addr  = drv_addr[2];
    assign if2.i_flush = drv_flush[2];
    assign if3.i_valid = drv_valid[3];
    assign if3.i_addr  = drv_addr[3];
    assign if3.i_flush = drv_flush[3];

    assign obs_valid[0] = if0.o_valid;
    assign obs_inst[0]  = 128'(if0.o_inst);
    assign obs_ok[0]    = 4'(if0.o_lane_ok);
    assign obs_err[0]   = if0.o_err;
    assign obs_infl[0]  = 4'(if0.o_inflight);
    assign obs_valid[1] = if1.o_valid;
    assign obs_inst[1]  = 128'(if1.o_inst);
    assign obs_ok[1]    = 4'(if1.o_lane_ok);
    assign obs_err[1]   = if1.o_err;
    assign obs_infl[1]  = 4'(if1.o_inflight);
    assign obs_valid[2] = if2.o_valid;
    assign obs_inst[2]  = 128'(if2.o_inst);
    assign obs_ok[2]    = 4'(if2.o_lane_ok);
    assign obs_err[2]   = if2.o_err;
    assign obs_infl[2]  = 4'(if2.o_inflight);
    assign obs_valid[3] = if3.o_valid;
    assign obs_inst[3]  = 128'(if3.o_inst);
    assign obs_ok[3]    = 4'(if3.o_lane_ok);
    assign obs_err[3]   = if3.o_err;
    assign obs_infl[3]  = 4'(if3.o_inflight);

    int lat [NI] = '{6, 6, 1, 8};
    int nf  [NI] = '{1, 2, 4, 4};

    // Model: each accepted request is scheduled in a slot keyed by its due edge.
    bit           pend_v [NI][16];
    logic [63:0]  pend_a [NI][16];
    logic         exp_valid [NI];
    logic [127:0] exp_inst  [NI];
    logic [3:0]   exp_ok    [NI];
    logic         exp_err   [NI];
    logic [3:0]   exp_infl  [NI];
    logic [31:0]  ref_mem [MAXI];
    int edge_no;
    int checks;
    int failures;
    bit verbose;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] inst;
        logic [1:0]  ok;
        logic        err;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void resp_model(input logic [63:0] addr, input int n,
                                       output logic [127:0] inst, output logic [3:0] ok,
                                       output logic err);
        longint unsigned idx;
        bit mis;
        idx  = longint'(addr >> 2);
        mis  = (addr[1:0] != 2'b00);
        inst = '0;
        ok   = '0;
        err  = mis || (idx >= longint'(MAXI));
        if (!mis) begin
            for (int j = 0; j < n; j++) begin
                if (idx + longint'(j) < longint'(MAXI)) begin
                    inst[j*32 +: 32] = ref_mem[int'(idx + longint'(j))];
                    ok[j] = 1'b1;
                end
            end
        end
    endfunction

    task automatic model_edge();
        int slot;
        edge_no++;
        slot = edge_no % 16;
        for (int k = 0; k < NI; k++) begin
            exp_valid[k] = 1'b0;
            exp_inst[k]  = '0;
            exp_ok[k]    = '0;
            exp_err[k]   = 1'b0;
            if (rst) begin
                for (int s = 0; s < 16; s++) pend_v[k][s] = 1'b0;
            end else begin
                if (pend_v[k][slot]) begin
                    exp_valid[k] = 1'b1;
                    resp_model(pend_a[k][slot], nf[k], exp_inst[k], exp_ok[k], exp_err[k]);
                    pend_v[k][slot] = 1'b0;
                end
                if (drv_flush[k]) begin
                    for (int s = 0; s < 16; s++) pend_v[k][s] = 1'b0;
                end
                if (drv_valid[k]) begin
                    pend_v[k][(edge_no + lat[k]) % 16] = 1'b1;
                    pend_a[k][(edge_no + lat[k]) % 16] = drv_addr[k];
                end
            end
            exp_infl[k] = '0;
            for (int s = 0; s < 16; s++) exp_infl[k] += 4'(pend_v[k][s]);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("dut%0d valid e%0d", k, edge_no), 128'(obs_valid[k]), 128'(exp_valid[k]));
            check($sformatf("dut%0d inst e%0d", k, edge_no), obs_inst[k], exp_inst[k]);
            check($sformatf("dut%0d lane_ok e%0d", k, edge_no), 128'(obs_ok[k]), 128'(exp_ok[k]));
            check($sformatf("dut%0d err e%0d", k, edge_no), 128'(obs_err[k]), 128'(exp_err[k]));
            check($sformatf("dut%0d inflight e%0d", k, edge_no), 128'(obs_infl[k]), 128'(exp_infl[k]));
            if (verbose && exp_valid[k])
                $display("edge %0d dut%0d resp inst=%h ok=%b err=%b", edge_no, k,
                         obs_inst[k], obs_ok[k], obs_err[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            drv_valid[k] = 1'b0;
            drv_flush[k] = 1'b0;
            drv_addr[k]  = '0;
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       return 64'($urandom_range(0, 259)) << 2;
        else if (sel < 8)  return (64'($urandom_range(0, 259)) << 2) | 64'($urandom_range(1, 3));
        else if (sel == 8) return 64'hFFFF_FFFF_FFFF_FFF0 | (64'($urandom_range(0, 3)) << 2);
        else               return 64'($urandom_range(250, 255)) << 2;
    endfunction

    initial begin
        int cnt;
        int peak;
        logic [127:0] cap;
        checks   = 0;
        failures = 0;
        edge_no  = 0;
        verbose  = 1'b1;
        rst      = 1'b1;
        idle_all();
        for (int k = 0; k < NI; k++) begin
            exp_valid[k] = 1'b0; exp_inst[k] = '0; exp_ok[k] = '0;
            exp_err[k]   = 1'b0; exp_infl[k] = '0;
            for (int s = 0; s < 16; s++) begin
                pend_v[k][s] = 1'b0;
                pend_a[k][s] = '0;
            end
        end
        for (int i = 0; i < MAXI; i++) ref_mem[i] = $urandom;
        ref_mem[3] = 32'h00A00093;
        for (int i = 0; i < MAXI; i++) begin
            u0.mem[i] = ref_mem[i];
            u1.mem[i] = ref_mem[i];
            u2.mem[i] = ref_mem[i];
            u3.mem[i] = ref_mem[i];
        end
        vecs[0] = '{64'd1020, {32'd0, ref_mem[255]}, 2'b01, 1'b0};
        vecs[1] = '{64'd1024, 64'd0, 2'b00, 1'b1};
        vecs[2] = '{64'd2, 64'd0, 2'b00, 1'b1};
        vecs[3] = '{64'd0, {ref_mem[1], ref_mem[0]}, 2'b11, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 2'b00, 1'b1};
        vecs[5] = '{64'd1016, {ref_mem[255], ref_mem[254]}, 2'b11, 1'b0};
        vecs[6] = '{64'd1022, 64'd0, 2'b00, 1'b1};

        #3;
        compare_all();
        tick();
        tick();
        rst = 1'b0;

        // Single fetch of word 3.
        drv_valid[0] = 1'b1; drv_addr[0] = 64'h0C;
        tick();
        idle_all();
        for (int t = 1; t <= 6; t++) begin
            tick();
            check($sformatf("single_valid_t%0d", t), 128'(obs_valid[0]), 128'(t == 6));
        end
        check("single_inst", obs_inst[0], 128'h00A00093);
        check("single_err", 128'(obs_err[0]), 128'd0);
        tick();

        // Streaming four back-to-back fetches.
        peak = 0; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drv_valid[0] = 1'b1; drv_addr[0] = 64'(i * 4);
            tick();
            if (int'(obs_infl[0]) > peak) peak = int'(obs_infl[0]);
        end
        idle_all();
        for (int t = 0; t < 8; t++) begin
            tick();
            if (obs_valid[0]) cnt++;
            if (int'(obs_infl[0]) > peak) peak = int'(obs_infl[0]);
        end
        check("stream_peak_inflight", 128'(peak), 128'd4);
        check("stream_resp_count", 128'(cnt), 128'd4);

        // Flush with redirect to 0x40.
        for (int i = 0; i < 3; i++) begin
            drv_valid[0] = 1'b1; drv_addr[0] = 64'(16 + i * 4);
            tick();
        end
        drv_valid[0] = 1'b1; drv_flush[0] = 1'b1; drv_addr[0] = 64'h40;
        tick();
        check("flush_inflight", 128'(obs_infl[0]), 128'd1);
        idle_all();
        cnt = 0; cap = '0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (obs_valid[0]) begin
                cnt++;
                cap = obs_inst[0];
                check("flush_resp_time", 128'(t), 128'd6);
            end
        end
        check("flush_resp_count", 128'(cnt), 128'd1);
        check("flush_resp_inst", cap, 128'(ref_mem[16]));

        // Boundary table on the two-lane instance.
        for (int i = 0; i < 7; i++) begin
            drv_valid[1] = 1'b1; drv_addr[1] = vecs[i].addr;
            tick();
            idle_all();
            for (int t = 1; t <= 5; t++) tick();
            check($sformatf("vec%0d early_valid", i), 128'(obs_valid[1]), 128'd0);
            tick();
            check($sformatf("vec%0d valid", i), 128'(obs_valid[1]), 128'd1);
            check($sformatf("vec%0d inst", i), obs_inst[1], 128'(vecs[i].inst));
            check($sformatf("vec%0d lane_ok", i), 128'(obs_ok[1]), 128'(vecs[i].ok));
            check($sformatf("vec%0d err", i), 128'(obs_err[1]), 128'(vecs[i].err));
            tick();
        end

        // Asynchronous reset with three fetches in flight.
        for (int i = 0; i < 3; i++) begin
            drv_valid[0] = 1'b1; drv_addr[0] = 64'(i * 4);
            tick();
        end
        idle_all();
        check("pre_reset_inflight", 128'(obs_infl[0]), 128'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 128'(obs_valid[0]), 128'd0);
        check("async_rst_inflight", 128'(obs_infl[0]), 128'd0);
        check("async_rst_inst", obs_inst[0], 128'd0);
        tick();
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (obs_valid[0]) cnt++;
        end
        check("post_reset_no_resp", 128'(cnt), 128'd0);

        // Random traffic on every instance against the schedule model.
        verbose = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NI; k++) begin
                drv_valid[k] = ($urandom_range(0, 3) != 0);
                drv_flush[k] = ($urandom_range(0, 9) == 0);
                drv_addr[k]  = rand_addr();
            end
            tick();
        end
        idle_all();
        for (int t = 0; t < 10; t++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
